// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: latches two WIDTH-bit operands on start, resolves
// one bit per clock LSB first through a single sum/carry cell, then strobes done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             s_bit;
  logic             c_next;

  // A request is honoured only outside ADD; a start mid-operation is dropped.
  assign accept = start && (state != ADD);
  assign last   = (cnt == CW'(WIDTH - 1));

  // The one full-adder cell every bit position passes through.
  assign s_bit       = opa[0] ^ opb[0] ^ c;
  assign c_next      = (opa[0] & opb[0]) | (c & (opa[0] ^ opb[0]));
  assign result_next = {s_bit, result[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last) state_next = DONE;
      DONE:    state_next = start ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      result <= '0;
      sum    <= '0;
      carry  <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and force the initial carry.
      opa    <= A;
      opb    <= sub ? ~B : B;
      c      <= sub ? 1'b1 : cin;
      cnt    <= '0;
      result <= '0;
    end else if (state == ADD) begin
      opa    <= opa >> 1;
      opb    <= opb >> 1;
      c      <= c_next;
      result <= result_next;
      if (last) begin
        sum   <= result_next;
        carry <= c_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state == ADD);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed and random ops at WIDTH=8, plus
// exhaustive operand sweeps at WIDTH=2 and WIDTH=3 against plain arithmetic.
module tb_serial_adder;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst_n8, start8, sub8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, carry8;

  // WIDTH=2 and WIDTH=3 instances share control inputs
  logic       rst_ns, start_s, sub_s, cin_s;
  logic [1:0] a2, b2, sum2;
  logic [2:0] a3, b3, sum3;
  logic       busy2, done2, carry2, busy3, done3, carry3;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .sub(sub8), .cin(cin8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_ns), .start(start_s), .sub(sub_s), .cin(cin_s),
    .A(a2), .B(b2), .busy(busy2), .done(done2), .sum(sum2), .carry(carry2)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_ns), .start(start_s), .sub(sub_s), .cin(cin_s),
    .A(a3), .B(b3), .busy(busy3), .done(done3), .sum(sum3), .carry(carry3)
  );

  exp_t q8[$];
  exp_t q2[$];
  exp_t q3[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Reference: modular add with carry-out, or subtract with not-borrow flag.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic s);
    longint unsigned m, av, bv, t;
    exp_t e;
    m  = 64'd1 << w;
    av = 64'(a) % m;
    bv = 64'(b) % m;
    if (s) begin
      t       = av + m - bv;
      e.carry = (av >= bv);
    end else begin
      t       = av + bv + 64'(c);
      e.carry = (t >= m);
    end
    e.sum = 32'(t % m);
    return e;
  endfunction

  // Monitors: pop the oldest expectation whenever a done strobe appears.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      check(busy8 === 1'b0, "w8_busy_with_done", 64'(busy8), 0);
      if (q8.size() == 0) begin
        check(1'b0, "w8_unexpected_done", {carry8, sum8}, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check({carry8, sum8} === {e.carry, e.sum[7:0]}, "w8_result",
              {carry8, sum8}, {e.carry, e.sum[7:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        check(1'b0, "w2_unexpected_done", {carry2, sum2}, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        check({carry2, sum2} === {e.carry, e.sum[1:0]}, "w2_result",
              {carry2, sum2}, {e.carry, e.sum[1:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        check(1'b0, "w3_unexpected_done", {carry3, sum3}, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check({carry3, sum3} === {e.carry, e.sum[2:0]}, "w3_result",
              {carry3, sum3}, {e.carry, e.sum[2:0]});
      end
    end
  end

  // Called on a negedge; returns on the negedge right after the start edge (k=1),
  // with the operand inputs scrambled to prove they are not re-sampled.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back(model(8, 32'(a), 32'(b), c, s));
    @(negedge clk);
    start8 = 1'b0;
    a8   = 8'($urandom);
    b8   = 8'($urandom);
    cin8 = 1'($urandom);
    sub8 = 1'($urandom);
  endtask

  // k counts negedges after the start edge; done is due at k = WIDTH+1.
  task automatic wait_done8(input int k0, output int k, output int busy_cnt);
    k = k0;
    busy_cnt = 0;
    while (done8 !== 1'b1 && k < 100) begin
      if (busy8 === 1'b1) busy_cnt++;
      @(negedge clk);
      k++;
    end
    if (done8 !== 1'b1) check(1'b0, "w8_done_timeout", 64'(k), 9);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, bc, n;
    rst_n8 = 1'b0; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    rst_ns = 1'b0; start_s = 1'b0; sub_s = 1'b0; cin_s = 1'b0;
    a2 = '0; b2 = '0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    check({busy8, done8, carry8, sum8} === 11'd0, "reset_w8",
          {busy8, done8, carry8, sum8}, 0);
    check({busy2, done2, carry2, sum2, busy3, done3, carry3, sum3} === 11'd0, "reset_small",
          {busy2, done2, carry2, sum2, busy3, done3, carry3, sum3}, 0);
    rst_n8 = 1'b1;
    rst_ns = 1'b1;
    @(negedge clk);

    // Basic add: latency and busy width
    issue8(8'h3C, 8'h0F, 1'b0, 1'b0);
    wait_done8(1, k, bc);
    check(k == 9, "t1_done_cycle", 64'(k), 9);
    check(bc == 8, "t1_busy_cycles", 64'(bc), 8);
    repeat (3) @(negedge clk);
    check({done8, busy8, sum8} === {2'b00, 8'h4B}, "t1_sum_hold", {done8, busy8, sum8}, 8'h4B);

    // Overflow and carry-in
    issue8(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done8(1, k, bc);
    @(negedge clk);
    issue8(8'h7F, 8'h00, 1'b1, 1'b0);
    wait_done8(1, k, bc);
    @(negedge clk);

    // Start during ADD is ignored; done still lands at k=9
    issue8(8'h3C, 8'h0F, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(4, k, bc);
    check(k == 9, "ignored_start_latency", 64'(k), 9);

    // Back-to-back start in the DONE cycle
    issue8(8'h01, 8'h01, 1'b0, 1'b0);
    check(busy8 === 1'b1, "b2b_busy", 64'(busy8), 1);
    wait_done8(1, k, bc);
    check(k == 9 && bc == 8, "b2b_done_cycle", 64'(k), 9);

    // Random ops, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1) @(negedge clk);
      issue8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait_done8(1, k, bc);
    end
    @(negedge clk);

    // Subtract: not-borrow set, then borrow with cin ignored (leaves sum=0xFF)
    issue8(8'h10, 8'h01, 1'b0, 1'b1);
    wait_done8(1, k, bc);
    @(negedge clk);
    issue8(8'h01, 8'h02, 1'b1, 1'b1);
    wait_done8(1, k, bc);
    @(negedge clk);

    // Reset at E4 (with a competing start) aborts with no done strobe
    issue8(8'h3C, 8'h0F, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n8 = 1'b0;
    start8 = 1'b1;
    @(negedge clk);
    check({busy8, done8, carry8, sum8} === 11'd0, "mid_reset",
          {busy8, done8, carry8, sum8}, 0);
    void'(q8.pop_back());
    rst_n8 = 1'b1;
    start8 = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) n++;
    end
    check(n == 0, "no_activity_after_reset", 64'(n), 0);

    // Exhaustive sweep at WIDTH=3 (and WIDTH=2 on the low bits)
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          for (int s = 0; s < 2; s++) begin
            a3 = 3'(a); b3 = 3'(b); a2 = a3[1:0]; b2 = b3[1:0];
            cin_s = 1'(c); sub_s = 1'(s); start_s = 1'b1;
            q3.push_back(model(3, 32'(a3), 32'(b3), cin_s, sub_s));
            q2.push_back(model(2, 32'(a2), 32'(b2), cin_s, sub_s));
            @(negedge clk);
            start_s = 1'b0;
            n = 0;
            while (done3 !== 1'b1 && n < 20) begin
              @(negedge clk);
              n++;
            end
            if (done3 !== 1'b1) check(1'b0, "w3_done_timeout", 64'(n), 3);
          end
        end
      end
    end

    repeat (6) @(negedge clk);
    check(q8.size() == 0, "w8_queue_drained", 64'(q8.size()), 0);
    check(q2.size() == 0, "w2_queue_drained", 64'(q2.size()), 0);
    check(q3.size() == 0, "w3_queue_drained", 64'(q3.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
